// File: rtl/bus_arbiter_if.sv
// Agent/host Avalon-MM read/write port bundle shared by the arbiter's requesters and downstream bus.
interface bus_arbiter_if;
    logic [31:0] address;
    logic [3:0]  byteenable;
    logic        read;
    logic        write;
    logic [31:0] host_to_agent;
    logic [31:0] agent_to_host;
    logic        waitrequest;
    logic        readdatavalid;

    modport master (
        output address, byteenable, read, write, host_to_agent,
        input  agent_to_host, waitrequest, readdatavalid
    );

    modport slave (
        input  address, byteenable, read, write, host_to_agent,
        output agent_to_host, waitrequest, readdatavalid
    );
endinterface

// File: rtl/bus_arbiter.sv
// Round-robin two-host arbiter for a shared Avalon-MM port, one grant per transaction,
// with a watchdog that aborts stalled transactions and reports them as bus errors.
module bus_arbiter #(
    parameter int unsigned TIMEOUT = 256
) (
    input  logic         clk,
    input  logic         rst,
    bus_arbiter_if.slave  ifetch,
    bus_arbiter_if.slave  data,
    bus_arbiter_if.master mem,
    output logic [1:0]   grant,
    output logic         bus_error,
    output logic         error_source
);

    localparam logic [1:0]  IDLE     = 2'd0;
    localparam logic [1:0]  BUSY0    = 2'd1;
    localparam logic [1:0]  BUSY1    = 2'd2;
    localparam bit          WD_ON    = (TIMEOUT != 0);
    localparam logic [15:0] TMO_LAST = 16'(TIMEOUT - 1);

    logic [1:0]  state, state_nxt;
    logic        last_grant;
    logic [15:0] wait_cnt;

    logic req0, req1;
    logic busy, owner;
    logic own_rd, own_wr, own_req;
    logic complete, abort;
    logic [31:0] rsp_data;

    // A host asserting both read and write is served as a plain read.
    always_comb begin
        req0     = ifetch.read | ifetch.write;
        req1     = data.read | data.write;
        busy     = (state == BUSY0) || (state == BUSY1);
        owner    = (state == BUSY1);
        own_rd   = owner ? data.read : ifetch.read;
        own_wr   = owner ? (data.write & ~data.read) : (ifetch.write & ~ifetch.read);
        own_req  = own_rd | own_wr;
        complete = busy && own_req && !mem.waitrequest && (!own_rd || mem.readdatavalid);
        abort    = WD_ON && busy && own_req && (wait_cnt == TMO_LAST) && !complete;
    end

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE: begin
                if (req0 && req1)
                    state_nxt = last_grant ? BUSY0 : BUSY1;
                else if (req0)
                    state_nxt = BUSY0;
                else if (req1)
                    state_nxt = BUSY1;
            end
            BUSY0, BUSY1: begin
                if (!own_req || complete || abort)
                    state_nxt = IDLE;
            end
            default: state_nxt = IDLE;
        endcase
    end

    // A dropped request returns to IDLE without touching last_grant or the error status.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state        <= IDLE;
            last_grant   <= 1'b1;
            wait_cnt     <= '0;
            error_source <= 1'b0;
        end else begin
            state <= state_nxt;
            if (complete || abort)
                last_grant <= owner;
            if (abort)
                error_source <= owner;
            if (busy && !complete)
                wait_cnt <= wait_cnt + 16'd1;
            else
                wait_cnt <= '0;
        end
    end

    always_comb begin
        mem.read          = busy && own_rd && !abort;
        mem.write         = busy && own_wr && !abort;
        mem.address       = '0;
        mem.byteenable    = '0;
        mem.host_to_agent = '0;
        if (state == BUSY0) begin
            mem.address       = ifetch.address;
            mem.byteenable    = ifetch.byteenable;
            mem.host_to_agent = ifetch.host_to_agent;
        end else if (state == BUSY1) begin
            mem.address       = data.address;
            mem.byteenable    = data.byteenable;
            mem.host_to_agent = data.host_to_agent;
        end
    end

    // On abort the owner is released with zeroed read data instead of the agent's response.
    always_comb begin
        rsp_data             = abort ? '0 : mem.agent_to_host;
        ifetch.agent_to_host = rsp_data;
        data.agent_to_host   = rsp_data;
        ifetch.waitrequest   = 1'b1;
        ifetch.readdatavalid = 1'b0;
        data.waitrequest     = 1'b1;
        data.readdatavalid   = 1'b0;
        if (state == BUSY0) begin
            ifetch.waitrequest   = abort ? 1'b0 : mem.waitrequest;
            ifetch.readdatavalid = abort ? own_rd : mem.readdatavalid;
        end else if (state == BUSY1) begin
            data.waitrequest     = abort ? 1'b0 : mem.waitrequest;
            data.readdatavalid   = abort ? own_rd : mem.readdatavalid;
        end
    end

    always_comb begin
        grant     = {state == BUSY1, state == BUSY0};
        bus_error = abort;
    end

endmodule

// File: tb/tb_bus_arbiter.sv
// Directed scenarios plus randomized two-host traffic against a transaction-level scoreboard.
module tb_bus_arbiter;
    localparam int TMO = 8;

    typedef struct {
        logic        wr;
        logic        hang;
        logic [1:0]  waits;
        logic [31:0] addr;
        logic [3:0]  be;
        logic [31:0] wdata;
    } txn_t;

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    bus_arbiter_if ifetch_bus ();
    bus_arbiter_if data_bus ();
    bus_arbiter_if mem_bus ();

    logic [1:0] grant;
    logic       bus_error;
    logic       error_source;

    bus_arbiter #(.TIMEOUT(TMO)) dut (
        .clk          (clk),
        .rst          (rst),
        .ifetch       (ifetch_bus),
        .data         (data_bus),
        .mem          (mem_bus),
        .grant        (grant),
        .bus_error    (bus_error),
        .error_source (error_source)
    );

    logic        drv_read  [2];
    logic        drv_write [2];
    logic [31:0] drv_addr  [2];
    logic [3:0]  drv_be    [2];
    logic [31:0] drv_wdata [2];
    logic        agt_wait, agt_rdv;
    logic [31:0] agt_rdata;

    assign ifetch_bus.read          = drv_read[0];
    assign ifetch_bus.write         = drv_write[0];
    assign ifetch_bus.address       = drv_addr[0];
    assign ifetch_bus.byteenable    = drv_be[0];
    assign ifetch_bus.host_to_agent = drv_wdata[0];
    assign data_bus.read            = drv_read[1];
    assign data_bus.write           = drv_write[1];
    assign data_bus.address         = drv_addr[1];
    assign data_bus.byteenable      = drv_be[1];
    assign data_bus.host_to_agent   = drv_wdata[1];
    assign mem_bus.waitrequest      = agt_wait;
    assign mem_bus.readdatavalid    = agt_rdv;
    assign mem_bus.agent_to_host    = agt_rdata;

    logic [1:0]  o_wait, o_rdv;
    logic [31:0] o_rdata [2];
    assign o_wait     = {data_bus.waitrequest, ifetch_bus.waitrequest};
    assign o_rdv      = {data_bus.readdatavalid, ifetch_bus.readdatavalid};
    assign o_rdata[0] = ifetch_bus.agent_to_host;
    assign o_rdata[1] = data_bus.agent_to_host;

    int total = 0;
    int bad   = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
        end
    endtask

    function automatic logic [31:0] rdfun(input logic [31:0] a);
        return a ^ 32'h5A5A_A5A5;
    endfunction

    task automatic idle_all();
        for (int h = 0; h < 2; h++) begin
            drv_read[h]  = 1'b0;
            drv_write[h] = 1'b0;
            drv_addr[h]  = '0;
            drv_be[h]    = '0;
            drv_wdata[h] = '0;
        end
        agt_wait  = 1'b1;
        agt_rdv   = 1'b0;
        agt_rdata = '0;
    endtask

    task automatic set_rd(input int h, input logic [31:0] a);
        drv_read[h] = 1'b1;
        drv_addr[h] = a;
        drv_be[h]   = 4'hF;
    endtask

    // Randomized-phase state shared by driver, agent and monitor
    txn_t sb0[$];
    txn_t sb1[$];
    logic busy [2];
    logic done [2];
    int   gcyc [2];
    logic rand_on = 1'b0;
    logic issuing = 1'b0;
    logic exp_src = 1'b0;
    int   agt_cnt = 0;
    logic [1:0] exp_g [6];

    initial begin
        #500000;
        $display("FAIL sim_limit: simulation did not finish in time");
        $fatal(1, "time limit");
    end

    // Host driver: at most one outstanding transaction per host.
    initial forever begin
        @(negedge clk);
        if (rand_on) begin
            for (int h = 0; h < 2; h++) begin
                if (done[h]) begin
                    drv_read[h]  = 1'b0;
                    drv_write[h] = 1'b0;
                    busy[h]      = 1'b0;
                    done[h]      = 1'b0;
                end
                if (!busy[h] && issuing && $urandom_range(0, 2) == 0) begin
                    txn_t t;
                    logic [31:0] a;
                    t.wr    = 1'($urandom_range(0, 1));
                    t.hang  = ($urandom_range(0, 9) == 0);
                    t.waits = 2'($urandom_range(0, 3));
                    a       = $urandom;
                    a[4]    = t.hang;
                    a[3:2]  = t.waits;
                    a[1:0]  = 2'b00;
                    t.addr  = a;
                    t.be    = 4'($urandom_range(1, 15));
                    t.wdata = $urandom;
                    if (h == 0) sb0.push_back(t);
                    else        sb1.push_back(t);
                    drv_addr[h]  = t.addr;
                    drv_be[h]    = t.be;
                    drv_wdata[h] = t.wdata;
                    drv_read[h]  = !t.wr;
                    drv_write[h] = t.wr;
                    busy[h]      = 1'b1;
                    gcyc[h]      = 0;
                end
            end
        end
    end

    // Downstream agent: wait states and hang flag are encoded in address bits [4:2].
    initial forever begin
        @(negedge clk);
        #1;
        if (rand_on) begin
            if (mem_bus.read || mem_bus.write) begin
                if (!mem_bus.address[4] && agt_cnt == int'(mem_bus.address[3:2])) begin
                    agt_wait  = 1'b0;
                    agt_rdv   = mem_bus.read;
                    agt_rdata = rdfun(mem_bus.address);
                end else begin
                    agt_wait  = 1'b1;
                    agt_rdv   = 1'b0;
                    agt_rdata = $urandom;
                end
                agt_cnt++;
            end else begin
                agt_cnt   = 0;
                agt_wait  = 1'b1;
                agt_rdv   = 1'b0;
                agt_rdata = $urandom | 32'h1;
            end
        end
    end

    // Monitor: pops the expected result whenever a host sees its transaction end.
    initial forever begin
        @(negedge clk);
        #2;
        if (rand_on) begin
            logic berr_exp;
            berr_exp = 1'b0;
            chk("error_source", 32'(error_source), 32'(exp_src));
            for (int h = 0; h < 2; h++) begin
                if (busy[h] && !done[h]) begin
                    gcyc[h] += int'(grant[h]);
                    if (!o_wait[h] && (drv_write[h] || o_rdv[h])) begin
                        txn_t e;
                        logic ok;
                        ok = 1'b0;
                        if (h == 0) begin
                            ok = (sb0.size() != 0);
                            if (ok) e = sb0.pop_front();
                        end else begin
                            ok = (sb1.size() != 0);
                            if (ok) e = sb1.pop_front();
                        end
                        chk("sb_pop", 32'(ok), 32'd1);
                        if (ok) begin
                            chk("txn_cycles", 32'(gcyc[h]), e.hang ? 32'(TMO) : 32'(int'(e.waits) + 1));
                            chk("grant_owner", 32'(grant), (h == 0) ? 32'd1 : 32'd2);
                            chk("other_blocked", 32'(o_wait[1-h]), 32'd1);
                            if (!e.wr)
                                chk("rdata", o_rdata[h], e.hang ? 32'd0 : rdfun(e.addr));
                            if (e.hang) begin
                                chk("abort_mem_idle", 32'({mem_bus.read, mem_bus.write}), 32'd0);
                                berr_exp = 1'b1;
                                exp_src  = 1'(h);
                            end else begin
                                chk("mem_addr", mem_bus.address, e.addr);
                                chk("mem_ctl", 32'({mem_bus.byteenable, mem_bus.read, mem_bus.write}),
                                    32'({e.be, !e.wr, e.wr}));
                                if (e.wr) chk("mem_wdata", mem_bus.host_to_agent, e.wdata);
                            end
                        end
                        done[h] = 1'b1;
                    end
                end
            end
            chk("bus_error", 32'(bus_error), 32'(berr_exp));
        end
    end

    initial begin
        for (int h = 0; h < 2; h++) begin
            busy[h] = 1'b0;
            done[h] = 1'b0;
            gcyc[h] = 0;
        end
        exp_g[0] = 2'd0; exp_g[1] = 2'd1; exp_g[2] = 2'd0;
        exp_g[3] = 2'd2; exp_g[4] = 2'd0; exp_g[5] = 2'd1;
        idle_all();
        rst = 1'b1;

        // Reset state
        @(negedge clk); #1;
        chk("rst_grant", 32'(grant), 32'd0);
        chk("rst_status", 32'({bus_error, error_source}), 32'd0);
        chk("rst_mem_ctl", 32'({mem_bus.read, mem_bus.write, mem_bus.byteenable}), 32'd0);
        chk("rst_hosts", 32'({o_wait, o_rdv}), 32'b1100);
        rst = 1'b0;

        // Single zero-wait ifetch read
        @(negedge clk);
        set_rd(0, 32'h100);
        agt_wait = 1'b0; agt_rdv = 1'b1; agt_rdata = 32'hDEADBEEF;
        #1;
        chk("rd_c0_memread", 32'({mem_bus.read, grant}), 32'd0);
        @(negedge clk); #1;
        chk("rd_c1_grant", 32'(grant), 32'd1);
        chk("rd_c1_mem", 32'({mem_bus.read, mem_bus.write}), 32'b10);
        chk("rd_c1_addr", mem_bus.address, 32'h100);
        chk("rd_c1_resp", 32'({o_wait, o_rdv}), 32'b1001);
        chk("rd_c1_data", o_rdata[0], 32'hDEADBEEF);
        @(negedge clk);
        drv_read[0] = 1'b0;
        agt_wait = 1'b1; agt_rdv = 1'b0;
        #1;
        chk("rd_c2_idle", 32'({mem_bus.read, grant}), 32'd0);

        // Tie right after reset: ifetch first, then strict alternation
        @(negedge clk);
        rst = 1'b1; #1; rst = 1'b0;
        set_rd(0, 32'h200);
        set_rd(1, 32'h204);
        agt_wait = 1'b0; agt_rdv = 1'b1; agt_rdata = 32'h1111_2222;
        for (int k = 0; k < 6; k++) begin
            #1;
            chk($sformatf("tie_grant_%0d", k), 32'(grant), 32'(exp_g[k]));
            @(negedge clk);
        end
        drv_read[0] = 1'b0; drv_read[1] = 1'b0;
        agt_wait = 1'b1; agt_rdv = 1'b0;

        // Data write held off by three wait cycles; ifetch blocked meanwhile
        @(negedge clk);
        drv_write[1] = 1'b1; drv_addr[1] = 32'h2000; drv_be[1] = 4'b0011; drv_wdata[1] = 32'h12345678;
        #1;
        chk("ws_c0_grant", 32'(grant), 32'd0);
        for (int k = 1; k <= 3; k++) begin
            @(negedge clk);
            if (k == 1) set_rd(0, 32'h400);
            #1;
            chk($sformatf("ws_c%0d_state", k),
                32'({grant, o_wait, mem_bus.write, mem_bus.byteenable}), 32'({2'b10, 2'b11, 1'b1, 4'b0011}));
        end
        @(negedge clk);
        agt_wait = 1'b0;
        #1;
        chk("ws_c4_hs", 32'({o_wait, mem_bus.byteenable}), 32'({2'b01, 4'b0011}));
        chk("ws_c4_wdata", mem_bus.host_to_agent, 32'h12345678);
        @(negedge clk);
        drv_write[1] = 1'b0; agt_rdv = 1'b1; agt_rdata = 32'h0BADF00D;
        #1;
        chk("ws_c5_grant", 32'(grant), 32'd0);
        @(negedge clk); #1;
        chk("ws_c6_ifetch", 32'({grant, o_wait[0], o_rdv[0]}), 32'b0101);
        @(negedge clk);
        drv_read[0] = 1'b0; agt_wait = 1'b1; agt_rdv = 1'b0;

        // Watchdog abort on a data read that is never answered
        @(negedge clk);
        set_rd(1, 32'h3000);
        agt_rdata = 32'hBAD0BAD0;
        #1;
        chk("to_c0_grant", 32'(grant), 32'd0);
        for (int k = 1; k < TMO; k++) begin
            @(negedge clk); #1;
            chk($sformatf("to_c%0d_wait", k), 32'({bus_error, o_wait[1], grant, mem_bus.read}), 32'b01101);
        end
        @(negedge clk); #1;
        chk("to_abort_ctl", 32'({bus_error, mem_bus.read, o_wait[1], o_rdv[1]}), 32'b1001);
        chk("to_abort_data", o_rdata[1], 32'd0);
        @(negedge clk);
        drv_read[1] = 1'b0;
        #1;
        chk("to_after", 32'({grant, bus_error, error_source}), 32'b0001);

        // Asynchronous reset in the middle of an ifetch read
        @(negedge clk);
        set_rd(0, 32'h300);
        @(negedge clk); #1;
        chk("ar_busy", 32'({grant, mem_bus.read}), 32'b011);
        #2 rst = 1'b1;
        #1;
        chk("ar_ctl", 32'({grant, mem_bus.read, bus_error, error_source, o_wait, o_rdv}), 32'b000001100);
        chk("ar_addr", mem_bus.address, 32'd0);
        @(negedge clk);
        rst = 1'b0;
        agt_wait = 1'b0; agt_rdv = 1'b1; agt_rdata = 32'hCAFEF00D;
        #1;
        chk("ar_idle", 32'(grant), 32'd0);
        @(negedge clk); #1;
        chk("ar_regrant", 32'({grant, o_rdv[0]}), 32'b011);
        chk("ar_data", o_rdata[0], 32'hCAFEF00D);
        @(negedge clk);
        drv_read[0] = 1'b0; agt_wait = 1'b1; agt_rdv = 1'b0;

        // Dropped request leaves last_grant alone: next tie still goes to ifetch
        @(negedge clk);
        rst = 1'b1; #1; rst = 1'b0;
        set_rd(0, 32'h500);
        @(negedge clk); #1;
        chk("dr_busy", 32'(grant), 32'd1);
        @(negedge clk);
        drv_read[0] = 1'b0;
        #1;
        chk("dr_drop", 32'({mem_bus.read, bus_error}), 32'd0);
        @(negedge clk); #1;
        chk("dr_idle", 32'({grant, bus_error}), 32'd0);
        set_rd(0, 32'h600);
        set_rd(1, 32'h604);
        agt_wait = 1'b0; agt_rdv = 1'b1;
        @(negedge clk); #1;
        chk("dr_tie", 32'(grant), 32'd1);
        @(negedge clk);
        idle_all();

        // Randomized traffic
        #1 rand_on = 1'b1;
        issuing = 1'b1;
        repeat (3000) @(negedge clk);
        #3 issuing = 1'b0;
        for (int i = 0; i < 400; i++) begin
            if (!busy[0] && !busy[1]) break;
            @(negedge clk);
            #3;
        end
        chk("drain", 32'({busy[0], busy[1]}), 32'd0);
        chk("sb_left", 32'(sb0.size() + sb1.size()), 32'd0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
